// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic accumulator PE.
package pe_pkg;

   typedef enum logic {
      MODE_INT32  = 1'b0,
      MODE_INT8X4 = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/systolic_pe_acc_if.sv
// Result drain port of the PE: valid/ready handshake carrying one accumulator slot per beat.
interface systolic_pe_acc_if #(
   parameter int unsigned DW = 32
) ();

   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/pe_mac_pipe.sv
// MAC_LAT-deep multiply-accumulate pipeline with valid and slot-index sideband.
// PE_SAT_EN defined: accumulation saturates to the signed DW range; otherwise it wraps.
module pe_mac_pipe
   import pe_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned ACC_DEPTH = 4,
   parameter int unsigned MAC_LAT   = 2,
   localparam int unsigned SW       = $clog2(ACC_DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid_i,
   input  mode_t         in_mode_i,
   input  logic [DW-1:0] in_a_i,
   input  logic [DW-1:0] in_b_i,
   input  logic [DW-1:0] in_acc_i,
   input  logic [SW-1:0] in_slot_i,
   output logic          out_valid_o,
   output logic [SW-1:0] out_slot_o,
   output logic [DW-1:0] out_acc_o,
   output logic          pending_o
);

   logic [DW-1:0] dot_d;
   logic [DW-1:0] term_d;
   logic [DW-1:0] sum_d;

   // Four signed byte lanes summed into an 18-bit accumulator, then sign-extended.
   if (DW >= 32) begin : g_dot
      logic signed [7:0]  a8, b8;
      logic signed [15:0] prod16;
      logic signed [17:0] dot18;
      always_comb begin
         a8     = '0;
         b8     = '0;
         prod16 = '0;
         dot18  = '0;
         for (int i = 0; i < 4; i++) begin
            a8     = in_a_i[8*i +: 8];
            b8     = in_b_i[8*i +: 8];
            prod16 = 16'(a8) * 16'(b8);
            dot18  = dot18 + 18'(prod16);
         end
         dot_d = DW'(dot18);
      end
   end else begin : g_no_dot
      assign dot_d = '0;
   end

   always_comb begin
      term_d = in_a_i * in_b_i;
      if (in_mode_i == MODE_INT8X4) term_d = dot_d;
   end

`ifdef PE_SAT_EN
   localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};
   logic [DW:0] wide_d;
   always_comb begin
      wide_d = {in_acc_i[DW-1], in_acc_i} + {term_d[DW-1], term_d};
      sum_d  = wide_d[DW-1:0];
      if (wide_d[DW] != wide_d[DW-1]) sum_d = wide_d[DW] ? MIN_V : MAX_V;
   end
`else
   always_comb begin
      sum_d = in_acc_i + term_d;
   end
`endif

   if (MAC_LAT == 1) begin : g_lat1
      assign out_valid_o = in_valid_i;
      assign out_slot_o  = in_slot_i;
      assign out_acc_o   = sum_d;
      assign pending_o   = 1'b0;
   end else begin : g_latn
      localparam int unsigned NS = MAC_LAT - 1;
      logic [NS-1:0] vld_q;
      logic [SW-1:0] slot_q [NS];
      logic [DW-1:0] acc_q  [NS];

      // Result is computed at issue and delayed so the slot write lands MAC_LAT cycles later.
      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < int'(NS); s++) begin
               slot_q[s] <= '0;
               acc_q[s]  <= '0;
            end
         end else begin
            vld_q[0]  <= in_valid_i;
            slot_q[0] <= in_slot_i;
            acc_q[0]  <= sum_d;
            for (int s = 1; s < int'(NS); s++) begin
               vld_q[s]  <= vld_q[s-1];
               slot_q[s] <= slot_q[s-1];
               acc_q[s]  <= acc_q[s-1];
            end
         end
      end

      assign out_valid_o = vld_q[NS-1];
      assign out_slot_o  = slot_q[NS-1];
      assign out_acc_o   = acc_q[NS-1];
      assign pending_o   = |vld_q;
   end

endmodule

// File: rtl/systolic_pe_acc.sv
// Systolic PE: operand forwarding, multi-slot MAC accumulation, bias preload and drain FSM.
// Optional PE_SAT_EN selects saturating accumulation inside pe_mac_pipe.
module systolic_pe_acc
   import pe_pkg::*;
#(
   parameter int unsigned DW        = 32,
   parameter int unsigned ACC_DEPTH = 4,
   parameter int unsigned MAC_LAT   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DW-1:0]      a_left,
   input  logic               a_vld_left,
   output logic [DW-1:0]      a_right,
   output logic               a_vld_right,
   input  logic [DW-1:0]      b_up,
   input  logic               b_vld_up,
   output logic [DW-1:0]      b_down,
   output logic               b_vld_down,
   input  mode_t              mode,
   input  logic               ld_valid,
   input  logic [DW-1:0]      ld_data,
   input  logic               drain_start,
   systolic_pe_acc_if.master  res,
   output logic               drain_done,
   output logic               busy,
   output logic               err
);

   localparam int unsigned SW   = $clog2(ACC_DEPTH);
   localparam logic [SW-1:0] LAST = SW'(ACC_DEPTH - 1);

   if (ACC_DEPTH < 2 || (ACC_DEPTH & (ACC_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("systolic_pe_acc: ACC_DEPTH must be a power of two >= 2");
   end
   if (MAC_LAT < 1 || MAC_LAT > ACC_DEPTH) begin : g_bad_lat
      $error("systolic_pe_acc: MAC_LAT must be in 1..ACC_DEPTH for read-after-write safety");
   end

   state_t        state_q;
   logic [DW-1:0] slot_q [ACC_DEPTH];
   logic [SW-1:0] ld_ptr_q, cmp_ptr_q, drn_ptr_q;
   logic [DW-1:0] a_right_q, b_down_q, out_data_q;
   logic          a_vld_right_q, b_vld_down_q;
   logic          out_valid_q, drain_done_q, busy_q, err_q;

   logic          idle, fire_req, fire, proto_err;
   logic          mac_vld, mac_pending;
   logic [SW-1:0] mac_slot;
   logic [DW-1:0] mac_acc;

   assign idle      = (state_q == IDLE);
   assign fire_req  = a_vld_left & b_vld_up;
   assign fire      = idle & fire_req & ~ld_valid;
   // Unpaired valids, load/fire collisions and any load or fire outside IDLE.
   assign proto_err = (a_vld_left ^ b_vld_up) | (fire_req & (ld_valid | ~idle)) | (ld_valid & ~idle);

   pe_mac_pipe #(
      .DW        (DW),
      .ACC_DEPTH (ACC_DEPTH),
      .MAC_LAT   (MAC_LAT)
   ) u_mac (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (fire),
      .in_mode_i   (mode),
      .in_a_i      (a_left),
      .in_b_i      (b_up),
      .in_acc_i    (slot_q[cmp_ptr_q]),
      .in_slot_i   (cmp_ptr_q),
      .out_valid_o (mac_vld),
      .out_slot_o  (mac_slot),
      .out_acc_o   (mac_acc),
      .pending_o   (mac_pending)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         for (int i = 0; i < int'(ACC_DEPTH); i++) slot_q[i] <= '0;
         ld_ptr_q      <= '0;
         cmp_ptr_q     <= '0;
         drn_ptr_q     <= '0;
         a_right_q     <= '0;
         a_vld_right_q <= 1'b0;
         b_down_q      <= '0;
         b_vld_down_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         drain_done_q  <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         a_right_q     <= a_left;
         a_vld_right_q <= a_vld_left;
         b_down_q      <= b_up;
         b_vld_down_q  <= b_vld_up;
         drain_done_q  <= 1'b0;
         if (proto_err) err_q <= 1'b1;
         if (mac_vld) slot_q[mac_slot] <= mac_acc;

         unique case (state_q)
            IDLE: begin
               if (ld_valid) begin
                  slot_q[ld_ptr_q] <= ld_data;
                  ld_ptr_q         <= ld_ptr_q + SW'(1);
               end
               if (fire) cmp_ptr_q <= cmp_ptr_q + SW'(1);
               if (drain_start) begin
                  state_q <= FLUSH;
                  busy_q  <= 1'b1;
               end
            end
            FLUSH: begin
               if (!mac_pending) begin
                  state_q     <= DRAIN;
                  out_valid_q <= 1'b1;
                  out_data_q  <= slot_q[drn_ptr_q];
               end
            end
            DRAIN: begin
               if (out_valid_q && res.out_ready) begin
                  if (drn_ptr_q == LAST) begin
                     out_valid_q  <= 1'b0;
                     drain_done_q <= 1'b1;
                     busy_q       <= 1'b0;
                     state_q      <= IDLE;
                     for (int i = 0; i < int'(ACC_DEPTH); i++) slot_q[i] <= '0;
                     ld_ptr_q     <= '0;
                     cmp_ptr_q    <= '0;
                     drn_ptr_q    <= '0;
                  end else begin
                     drn_ptr_q  <= drn_ptr_q + SW'(1);
                     out_data_q <= slot_q[drn_ptr_q + SW'(1)];
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a_right       = a_right_q;
   assign a_vld_right   = a_vld_right_q;
   assign b_down        = b_down_q;
   assign b_vld_down    = b_vld_down_q;
   assign res.out_valid = out_valid_q;
   assign res.out_data  = out_data_q;
   assign drain_done    = drain_done_q;
   assign busy          = busy_q;
   assign err           = err_q;

endmodule
